vex_bus_arbiter: RTL and testbench
==================================

VEX_BUS_ARBITER -- requirements
Module: vex_bus_arbiter

Interface
REQ-001 SHALL have parameter PENDING_DEPTH, default 8, meaning max outstanding reads (power of two, 2..16).
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports iBus_cmd_valid in 1, iBus_cmd_ready out 1, iBus_cmd_payload_pc in 32  instruction fetch command.
REQ-005 SHALL have ports iBus_rsp_valid out 1, iBus_rsp_payload_inst out 32, iBus_rsp_payload_error out 1  fetch response.
REQ-006 SHALL have ports dBus_cmd_valid in 1, dBus_cmd_ready out 1, dBus_cmd_payload_wr in 1, dBus_cmd_payload_address in 32, dBus_cmd_payload_data in 32, dBus_cmd_payload_size in 2  data command.
REQ-007 SHALL have ports dBus_rsp_ready out 1, dBus_rsp_data out 32, dBus_rsp_error out 1  data read response (dBus_rsp_ready is the response strobe).
REQ-008 SHALL have ports mem_cmd_valid out 1, mem_cmd_ready in 1, mem_cmd_payload_wr out 1, mem_cmd_payload_address out 32, mem_cmd_payload_data out 32, mem_cmd_payload_size out 2  shared memory command.
REQ-009 SHALL have ports mem_rsp_valid in 1, mem_rsp_payload_data in 32, mem_rsp_payload_error in 1  shared memory response, in order, reads only.
REQ-010 SHALL have ports pending_count out clog2(PENDING_DEPTH)+1 (outstanding reads) and protocol_error out 1 (sticky).

Function
REQ-011 SHALL forward the granted command to mem_cmd_* combinationally (zero latency); iBus maps to wr=0, address=pc, data=0, size=2.
REQ-012 SHALL treat an iBus command and a dBus command with wr=0 as reads; dBus wr=1 as a write producing no response.
REQ-013 SHALL mark a read requester ineligible while pending_count==PENDING_DEPTH, even if a response pops that cycle; writes stay eligible.
REQ-014 SHALL, with lock clear, grant the single eligible requester, or, both eligible, the one opposite last_grant (round-robin).
REQ-015 SHALL set lock when mem_cmd_valid=1 and mem_cmd_ready=0, holding grant and payload source until handshake; lock clears on handshake.
REQ-016 SHALL assert <src>_cmd_ready = mem_cmd_ready only for the granted source; the other reads 0.
REQ-017 SHALL update last_grant to the source on each mem command handshake.
REQ-018 SHALL push the source ID into the pending FIFO on each read handshake.
REQ-019 SHALL route mem_rsp_valid to iBus_rsp_valid or dBus_rsp_ready per FIFO head, pop on that cycle, and broadcast rsp data/error to both payload outputs.
REQ-020 SHALL handle simultaneous push and pop in one cycle, pending_count unchanged; pointers wrap modulo PENDING_DEPTH.
REQ-021 SHALL, on mem_rsp_valid with FIFO empty, drop the response (no rsp strobes) and set protocol_error until reset.

Reset
REQ-022 SHALL on reset clear FIFO pointers, pending_count=0, lock=0, protocol_error=0, last_grant=SRC_DBUS (first conflict goes to iBus).
REQ-023 SHALL hold all *_ready/rsp strobe outputs and mem_cmd_valid at 0 while reset is asserted.
REQ-024 SHALL discard outstanding reads on reset mid-operation; post-reset responses hit REQ-021.

Structure
REQ-025 SHALL place src_t enum (SRC_IBUS=0, SRC_DBUS=1) and default PENDING_DEPTH constant in package vex_bus_pkg.
REQ-026 SHALL implement the ID tracker as sub-module vex_pending_fifo (1-bit entries, push/pop/count/empty/full).

Verification
REQ-027 SHALL cover: both cmd_valid at cycle 1 after reset, mem_cmd_ready=1 -> iBus granted first, dBus next cycle.
REQ-028 SHALL cover: dBus read at 0x100 with mem_cmd_ready=0 for 3 cycles, iBus raised meanwhile -> mem address stays 0x100 until handshake.
REQ-029 SHALL cover: 8 iBus reads, no responses -> pending_count=8, iBus_cmd_ready=0; dBus write still accepted.
REQ-030 SHALL cover: iBus read, dBus read, then responses 0xAAAA0001, 0xBBBB0002 -> iBus gets first, dBus second.
REQ-031 SHALL cover: mem_rsp_valid with pending_count=0 -> no rsp strobes, protocol_error=1 until reset.
REQ-032 SHALL cover: reset asserted with pending_count=3 -> count=0 immediately, outputs at reset values.

Source files
------------

// File: rtl/vex_bus_pkg.sv
// Shared types and defaults for the VexRiscv-style instruction/data bus arbiter.
package vex_bus_pkg;

    typedef enum logic {
        SRC_IBUS = 1'b0,
        SRC_DBUS = 1'b1
    } src_t;

    localparam int DEFAULT_PENDING_DEPTH = 8;

endpackage

// File: rtl/vex_pending_fifo.sv
// In-order tracker of which requester owns each outstanding read.
module vex_pending_fifo
    import vex_bus_pkg::*;
#(
    parameter int DEPTH = DEFAULT_PENDING_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  src_t                     pushId,
    input  logic                     pop,
    output src_t                     headId,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] COUNT_ONE = CW'(1);
    localparam logic [CW-1:0] COUNT_MAX = CW'(DEPTH);

    src_t            slots [DEPTH];
    logic [PW-1:0]   wrPtr;
    logic [PW-1:0]   rdPtr;
    logic            doPush;
    logic            doPop;

    assign empty  = (count == {CW{1'b0}});
    assign full   = (count == COUNT_MAX);
    assign doPush = push && !full;
    assign doPop  = pop && !empty;
    assign headId = slots[rdPtr];

    // Pointer and occupancy bookkeeping; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr <= {PW{1'b0}};
            rdPtr <= {PW{1'b0}};
            count <= {CW{1'b0}};
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count <= count + COUNT_ONE;
                2'b01:   count <= count - COUNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; cleared on reset so the head never reads as X.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= SRC_IBUS;
            end
        end else if (doPush) begin
            slots[wrPtr] <= pushId;
        end
    end

endmodule

// File: rtl/vex_bus_arbiter.sv
// Merges instruction fetch and data bus commands onto one memory port and
// routes in-order read responses back to whichever requester issued them.
module vex_bus_arbiter
    import vex_bus_pkg::*;
#(
    parameter int PENDING_DEPTH = DEFAULT_PENDING_DEPTH
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           iBus_cmd_valid,
    output logic                           iBus_cmd_ready,
    input  logic [31:0]                    iBus_cmd_payload_pc,
    output logic                           iBus_rsp_valid,
    output logic [31:0]                    iBus_rsp_payload_inst,
    output logic                           iBus_rsp_payload_error,
    input  logic                           dBus_cmd_valid,
    output logic                           dBus_cmd_ready,
    input  logic                           dBus_cmd_payload_wr,
    input  logic [31:0]                    dBus_cmd_payload_address,
    input  logic [31:0]                    dBus_cmd_payload_data,
    input  logic [1:0]                     dBus_cmd_payload_size,
    output logic                           dBus_rsp_ready,
    output logic [31:0]                    dBus_rsp_data,
    output logic                           dBus_rsp_error,
    output logic                           mem_cmd_valid,
    input  logic                           mem_cmd_ready,
    output logic                           mem_cmd_payload_wr,
    output logic [31:0]                    mem_cmd_payload_address,
    output logic [31:0]                    mem_cmd_payload_data,
    output logic [1:0]                     mem_cmd_payload_size,
    input  logic                           mem_rsp_valid,
    input  logic [31:0]                    mem_rsp_payload_data,
    input  logic                           mem_rsp_payload_error,
    output logic [$clog2(PENDING_DEPTH):0] pending_count,
    output logic                           protocol_error
);

    src_t lastGrant;
    src_t lockSrc;
    logic lock;
    src_t grantSrc;
    logic grantValid;
    logic ibusEligible;
    logic dbusEligible;
    logic cmdFire;
    logic cmdIsRead;
    logic fifoPush;
    logic fifoPop;
    src_t fifoHead;
    logic fifoEmpty;
    logic fifoFull;

    // A full tracker blocks reads even when a response frees a slot this cycle.
    assign ibusEligible = iBus_cmd_valid && !fifoFull;
    assign dbusEligible = dBus_cmd_valid && (dBus_cmd_payload_wr || !fifoFull);

    // Grant selection: a stalled command keeps its source, otherwise round-robin on conflict.
    always_comb begin
        grantSrc   = lastGrant;
        grantValid = 1'b0;
        if (lock) begin
            grantSrc   = lockSrc;
            grantValid = (lockSrc == SRC_IBUS) ? iBus_cmd_valid : dBus_cmd_valid;
        end else if (ibusEligible && dbusEligible) begin
            grantSrc   = (lastGrant == SRC_IBUS) ? SRC_DBUS : SRC_IBUS;
            grantValid = 1'b1;
        end else if (ibusEligible) begin
            grantSrc   = SRC_IBUS;
            grantValid = 1'b1;
        end else if (dbusEligible) begin
            grantSrc   = SRC_DBUS;
            grantValid = 1'b1;
        end else begin
            grantValid = 1'b0;
        end
    end

    // Payload mux from the granted source; instruction fetches are always word reads.
    always_comb begin
        mem_cmd_payload_wr      = 1'b0;
        mem_cmd_payload_address = 32'h0000_0000;
        mem_cmd_payload_data    = 32'h0000_0000;
        mem_cmd_payload_size    = 2'd0;
        if (grantValid) begin
            case (grantSrc)
                SRC_IBUS: begin
                    mem_cmd_payload_wr      = 1'b0;
                    mem_cmd_payload_address = iBus_cmd_payload_pc;
                    mem_cmd_payload_data    = 32'h0000_0000;
                    mem_cmd_payload_size    = 2'd2;
                end
                SRC_DBUS: begin
                    mem_cmd_payload_wr      = dBus_cmd_payload_wr;
                    mem_cmd_payload_address = dBus_cmd_payload_address;
                    mem_cmd_payload_data    = dBus_cmd_payload_data;
                    mem_cmd_payload_size    = dBus_cmd_payload_size;
                end
                default: begin
                    mem_cmd_payload_wr      = 1'b0;
                    mem_cmd_payload_address = 32'h0000_0000;
                    mem_cmd_payload_data    = 32'h0000_0000;
                    mem_cmd_payload_size    = 2'd0;
                end
            endcase
        end else begin
            mem_cmd_payload_wr = 1'b0;
        end
    end

    assign mem_cmd_valid  = grantValid && !reset;
    assign iBus_cmd_ready = mem_cmd_valid && mem_cmd_ready && (grantSrc == SRC_IBUS);
    assign dBus_cmd_ready = mem_cmd_valid && mem_cmd_ready && (grantSrc == SRC_DBUS);
    assign cmdFire        = mem_cmd_valid && mem_cmd_ready;
    assign cmdIsRead      = (grantSrc == SRC_IBUS) || !dBus_cmd_payload_wr;
    assign fifoPush       = cmdFire && cmdIsRead;

    // Responses with no outstanding read are swallowed and flagged instead.
    assign fifoPop        = mem_rsp_valid && !fifoEmpty && !reset;
    assign iBus_rsp_valid = fifoPop && (fifoHead == SRC_IBUS);
    assign dBus_rsp_ready = fifoPop && (fifoHead == SRC_DBUS);

    assign iBus_rsp_payload_inst  = mem_rsp_payload_data;
    assign iBus_rsp_payload_error = mem_rsp_payload_error;
    assign dBus_rsp_data          = mem_rsp_payload_data;
    assign dBus_rsp_error         = mem_rsp_payload_error;

    // Arbitration state: lock holds a stalled command, lastGrant steers round-robin.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock      <= 1'b0;
            lockSrc   <= SRC_IBUS;
            lastGrant <= SRC_DBUS;
        end else begin
            lock <= mem_cmd_valid && !mem_cmd_ready;
            if (mem_cmd_valid && !mem_cmd_ready) begin
                lockSrc <= grantSrc;
            end
            if (cmdFire) begin
                lastGrant <= grantSrc;
            end
        end
    end

    // Sticky flag for a response arriving while nothing is outstanding.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            protocol_error <= 1'b0;
        end else if (mem_rsp_valid && fifoEmpty) begin
            protocol_error <= 1'b1;
        end
    end

    vex_pending_fifo #(
        .DEPTH (PENDING_DEPTH)
    ) uPendingFifo (
        .clk    (clk),
        .reset  (reset),
        .push   (fifoPush),
        .pushId (grantSrc),
        .pop    (fifoPop),
        .headId (fifoHead),
        .count  (pending_count),
        .empty  (fifoEmpty),
        .full   (fifoFull)
    );

endmodule

// File: tb/tb_vex_bus_arbiter.sv
// Directed bench for vex_bus_arbiter with a queue of expected response owners.
module tb_vex_bus_arbiter;
    import vex_bus_pkg::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        iBus_cmd_valid, iBus_cmd_ready;
    logic [31:0] iBus_cmd_payload_pc;
    logic        iBus_rsp_valid, iBus_rsp_payload_error;
    logic [31:0] iBus_rsp_payload_inst;
    logic        dBus_cmd_valid, dBus_cmd_ready, dBus_cmd_payload_wr;
    logic [31:0] dBus_cmd_payload_address, dBus_cmd_payload_data;
    logic [1:0]  dBus_cmd_payload_size;
    logic        dBus_rsp_ready, dBus_rsp_error;
    logic [31:0] dBus_rsp_data;
    logic        mem_cmd_valid, mem_cmd_ready, mem_cmd_payload_wr;
    logic [31:0] mem_cmd_payload_address, mem_cmd_payload_data;
    logic [1:0]  mem_cmd_payload_size;
    logic        mem_rsp_valid, mem_rsp_payload_error;
    logic [31:0] mem_rsp_payload_data;
    logic [3:0]  pending_count;
    logic        protocol_error;

    int   total = 0;
    int   bad   = 0;
    src_t expQ[$];

    always #5 clk = ~clk;

    vex_bus_arbiter #(.PENDING_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .iBus_cmd_valid(iBus_cmd_valid), .iBus_cmd_ready(iBus_cmd_ready),
        .iBus_cmd_payload_pc(iBus_cmd_payload_pc),
        .iBus_rsp_valid(iBus_rsp_valid), .iBus_rsp_payload_inst(iBus_rsp_payload_inst),
        .iBus_rsp_payload_error(iBus_rsp_payload_error),
        .dBus_cmd_valid(dBus_cmd_valid), .dBus_cmd_ready(dBus_cmd_ready),
        .dBus_cmd_payload_wr(dBus_cmd_payload_wr),
        .dBus_cmd_payload_address(dBus_cmd_payload_address),
        .dBus_cmd_payload_data(dBus_cmd_payload_data),
        .dBus_cmd_payload_size(dBus_cmd_payload_size),
        .dBus_rsp_ready(dBus_rsp_ready), .dBus_rsp_data(dBus_rsp_data),
        .dBus_rsp_error(dBus_rsp_error),
        .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
        .mem_cmd_payload_wr(mem_cmd_payload_wr),
        .mem_cmd_payload_address(mem_cmd_payload_address),
        .mem_cmd_payload_data(mem_cmd_payload_data),
        .mem_cmd_payload_size(mem_cmd_payload_size),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_payload_data(mem_rsp_payload_data),
        .mem_rsp_payload_error(mem_rsp_payload_error),
        .pending_count(pending_count), .protocol_error(protocol_error)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // Drive one memory response and compare routing against the queue head.
    task automatic respond(input string tag, input logic [31:0] data, input logic err);
        src_t exp;
        mem_rsp_valid         = 1'b1;
        mem_rsp_payload_data  = data;
        mem_rsp_payload_error = err;
        settle();
        if (expQ.size() == 0) begin
            chk({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            exp = expQ.pop_front();
            chk({tag, "_iValid"}, {31'd0, iBus_rsp_valid}, {31'd0, exp == SRC_IBUS});
            chk({tag, "_dReady"}, {31'd0, dBus_rsp_ready}, {31'd0, exp == SRC_DBUS});
            chk({tag, "_iData"}, iBus_rsp_payload_inst, data);
            chk({tag, "_dData"}, dBus_rsp_data, data);
            chk({tag, "_dErr"}, {31'd0, dBus_rsp_error}, {31'd0, err});
        end
        tick();
        mem_rsp_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        iBus_cmd_valid = 1'b1; iBus_cmd_payload_pc = 32'h0000_1000;
        dBus_cmd_valid = 1'b1; dBus_cmd_payload_wr = 1'b0;
        dBus_cmd_payload_address = 32'h0000_0200; dBus_cmd_payload_data = 32'h0;
        dBus_cmd_payload_size = 2'd2;
        mem_cmd_ready = 1'b1; mem_rsp_valid = 1'b0;
        mem_rsp_payload_data = 32'h0; mem_rsp_payload_error = 1'b0;
        tick(); tick();
        settle();
        chk("rst_memValid", {31'd0, mem_cmd_valid}, 32'd0);
        chk("rst_iReady", {31'd0, iBus_cmd_ready}, 32'd0);
        chk("rst_dReady", {31'd0, dBus_cmd_ready}, 32'd0);
        chk("rst_count", {28'd0, pending_count}, 32'd0);
        chk("rst_perr", {31'd0, protocol_error}, 32'd0);

        // Conflict right after reset: iBus first, dBus on the next cycle.
        tick();
        reset = 1'b0;
        settle();
        chk("rr1_addr", mem_cmd_payload_address, 32'h0000_1000);
        chk("rr1_size", {30'd0, mem_cmd_payload_size}, 32'd2);
        chk("rr1_iReady", {31'd0, iBus_cmd_ready}, 32'd1);
        chk("rr1_dReady", {31'd0, dBus_cmd_ready}, 32'd0);
        expQ.push_back(SRC_IBUS);
        tick();
        settle();
        chk("rr2_addr", mem_cmd_payload_address, 32'h0000_0200);
        chk("rr2_dReady", {31'd0, dBus_cmd_ready}, 32'd1);
        chk("rr2_iReady", {31'd0, iBus_cmd_ready}, 32'd0);
        expQ.push_back(SRC_DBUS);
        tick();
        iBus_cmd_valid = 1'b0; dBus_cmd_valid = 1'b0;
        settle();
        chk("rr_count", {28'd0, pending_count}, 32'd2);
        respond("rsp1", 32'hAAAA_0001, 1'b0);
        respond("rsp2", 32'hBBBB_0002, 1'b1);
        settle();
        chk("rsp_count", {28'd0, pending_count}, 32'd0);

        // Stalled dBus read keeps the port even though iBus would win round-robin.
        dBus_cmd_valid = 1'b1; dBus_cmd_payload_address = 32'h0000_0100;
        mem_cmd_ready = 1'b0;
        settle();
        chk("lock0_addr", mem_cmd_payload_address, 32'h0000_0100);
        chk("lock0_valid", {31'd0, mem_cmd_valid}, 32'd1);
        tick();
        iBus_cmd_valid = 1'b1; iBus_cmd_payload_pc = 32'h0000_2000;
        for (int i = 1; i < 3; i++) begin
            settle();
            chk("lock_addr", mem_cmd_payload_address, 32'h0000_0100);
            chk("lock_iReady", {31'd0, iBus_cmd_ready}, 32'd0);
            tick();
        end
        mem_cmd_ready = 1'b1;
        settle();
        chk("lock_rel_addr", mem_cmd_payload_address, 32'h0000_0100);
        chk("lock_rel_dReady", {31'd0, dBus_cmd_ready}, 32'd1);
        expQ.push_back(SRC_DBUS);
        tick();
        dBus_cmd_valid = 1'b0;
        settle();
        chk("lock_next_addr", mem_cmd_payload_address, 32'h0000_2000);
        chk("lock_next_iReady", {31'd0, iBus_cmd_ready}, 32'd1);
        expQ.push_back(SRC_IBUS);
        tick();
        iBus_cmd_valid = 1'b0;
        respond("lrsp1", 32'h1234_5678, 1'b0);
        respond("lrsp2", 32'h8765_4321, 1'b0);

        // Fill the tracker with eight fetches.
        iBus_cmd_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            iBus_cmd_payload_pc = 32'h0000_3000 + 32'(4 * i);
            expQ.push_back(SRC_IBUS);
            tick();
        end
        settle();
        chk("full_count", {28'd0, pending_count}, 32'd8);
        chk("full_iReady", {31'd0, iBus_cmd_ready}, 32'd0);
        chk("full_memValid", {31'd0, mem_cmd_valid}, 32'd0);
        dBus_cmd_valid = 1'b1; dBus_cmd_payload_wr = 1'b1;
        dBus_cmd_payload_address = 32'h0000_0400; dBus_cmd_payload_data = 32'hDEAD_BEEF;
        settle();
        chk("full_wrReady", {31'd0, dBus_cmd_ready}, 32'd1);
        chk("full_wrFlag", {31'd0, mem_cmd_payload_wr}, 32'd1);
        chk("full_wrData", mem_cmd_payload_data, 32'hDEAD_BEEF);
        tick();
        dBus_cmd_valid = 1'b0; dBus_cmd_payload_wr = 1'b0;
        settle();
        chk("full_wrCount", {28'd0, pending_count}, 32'd8);
        // Popping while full must still refuse the fetch this cycle.
        mem_rsp_valid = 1'b1;
        settle();
        chk("fullpop_iReady", {31'd0, iBus_cmd_ready}, 32'd0);
        iBus_cmd_valid = 1'b0;
        respond("fpop", 32'h0000_0F00, 1'b0);
        settle();
        chk("fullpop_count", {28'd0, pending_count}, 32'd7);

        // Drain; one cycle pushes and pops together.
        for (int i = 0; i < 7; i++) begin
            if (i == 3) begin
                iBus_cmd_valid = 1'b1;
                settle();
                chk("pushpop_iReady", {31'd0, iBus_cmd_ready}, 32'd1);
                respond("pp", 32'h0000_5000, 1'b0);
                expQ.push_back(SRC_IBUS);
                iBus_cmd_valid = 1'b0;
                settle();
                chk("pushpop_count", {28'd0, pending_count}, 32'd4);
            end else begin
                respond("drain", 32'h0000_6000 + 32'(i), 1'b0);
            end
        end
        respond("drainLast", 32'h0000_7000, 1'b0);
        settle();
        chk("drain_count", {28'd0, pending_count}, 32'd0);
        chk("drain_perr", {31'd0, protocol_error}, 32'd0);

        // Stray response with nothing outstanding.
        mem_rsp_valid = 1'b1; mem_rsp_payload_data = 32'h0BAD_0BAD;
        settle();
        chk("stray_iValid", {31'd0, iBus_rsp_valid}, 32'd0);
        chk("stray_dReady", {31'd0, dBus_rsp_ready}, 32'd0);
        tick();
        mem_rsp_valid = 1'b0;
        tick(); tick();
        settle();
        chk("stray_perr", {31'd0, protocol_error}, 32'd1);

        // Reset in the middle of three outstanding fetches.
        iBus_cmd_valid = 1'b1;
        tick(); tick(); tick();
        settle();
        chk("mid_count3", {28'd0, pending_count}, 32'd3);
        reset = 1'b1;
        #1;
        chk("mid_count0", {28'd0, pending_count}, 32'd0);
        chk("mid_perr", {31'd0, protocol_error}, 32'd0);
        chk("mid_memValid", {31'd0, mem_cmd_valid}, 32'd0);
        chk("mid_iReady", {31'd0, iBus_cmd_ready}, 32'd0);
        expQ.delete();
        iBus_cmd_valid = 1'b0;
        tick();
        reset = 1'b0;
        mem_rsp_valid = 1'b1;
        settle();
        chk("post_iValid", {31'd0, iBus_rsp_valid}, 32'd0);
        chk("post_dReady", {31'd0, dBus_rsp_ready}, 32'd0);
        tick();
        mem_rsp_valid = 1'b0;
        settle();
        chk("post_perr", {31'd0, protocol_error}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
